// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between NUM_REQ
//               requesters, with registered operands and registered responses.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*WIDTH-1:0] req_op2,
    input  logic [NUM_REQ*4-1:0]     req_ctrl,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic                     resp_zero,
    output logic                     resp_lt,
    output logic                     resp_ltu,
    output logic                     resp_err,
    output logic [WIDTH-1:0]         alu_op1,
    output logic [WIDTH-1:0]         alu_op2,
    output logic [3:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     zero,
    input  logic                     lessSigend,
    input  logic                     lessUnsigend
);

    localparam int         c_IDX_W  = $clog2(NUM_REQ);
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_grant;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [WIDTH-1:0]   r_resp_result;
    logic               r_resp_zero;
    logic               r_resp_lt;
    logic               r_resp_ltu;
    logic               r_resp_err;
    logic [WIDTH-1:0]   r_alu_op1;
    logic [WIDTH-1:0]   r_alu_op2;
    logic [3:0]         r_alu_ctrl;

    logic               w_found;
    logic [c_IDX_W-1:0] w_winner;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_next_ptr;
    logic [NUM_REQ-1:0] w_grant_onehot;

    function automatic logic f_legal(input logic [3:0] ctrl);
        case (ctrl)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: f_legal = 1'b1;
            default:                                     f_legal = 1'b0;
        endcase
    endfunction

    // Scan from the farthest candidate back to r_ptr so the nearest valid wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == c_S_IDLE && w_found) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_next_ptr     = (r_grant == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                               : r_grant + c_IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_S_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_resp_valid  <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_lt     <= 1'b0;
            r_resp_ltu    <= 1'b0;
            r_resp_err    <= 1'b0;
            r_alu_op1     <= '0;
            r_alu_op2     <= '0;
            r_alu_ctrl    <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_winner;
                        r_alu_op1  <= req_op1[int'(w_winner)*WIDTH +: WIDTH];
                        r_alu_op2  <= req_op2[int'(w_winner)*WIDTH +: WIDTH];
                        r_alu_ctrl <= req_ctrl[int'(w_winner)*4 +: 4];
                        r_state    <= c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    // An illegal code never trusts whatever the ALU produced.
                    if (f_legal(r_alu_ctrl)) begin
                        r_resp_result <= alu_result;
                        r_resp_zero   <= zero;
                        r_resp_lt     <= lessSigend;
                        r_resp_ltu    <= lessUnsigend;
                        r_resp_err    <= 1'b0;
                    end else begin
                        r_resp_result <= '0;
                        r_resp_zero   <= 1'b0;
                        r_resp_lt     <= 1'b0;
                        r_resp_ltu    <= 1'b0;
                        r_resp_err    <= 1'b1;
                    end
                    r_resp_valid <= w_grant_onehot;
                    r_state      <= c_S_RESP;
                end
                c_S_RESP: begin
                    if (resp_ready[r_grant]) begin
                        r_resp_valid <= '0;
                        r_ptr        <= w_next_ptr;
                        r_state      <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign resp_lt     = r_resp_lt;
    assign resp_ltu    = r_resp_ltu;
    assign resp_err    = r_resp_err;
    assign alu_op1     = r_alu_op1;
    assign alu_op2     = r_alu_op2;
    assign alu_ctrl    = r_alu_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench: directed vector table, reset corner case
//               and randomized transactions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int c_W  = 32;
    localparam int c_NR = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [c_NR-1:0]    req_valid;
    logic [c_NR-1:0]    req_ready;
    logic [c_NR*c_W-1:0] req_op1;
    logic [c_NR*c_W-1:0] req_op2;
    logic [c_NR*4-1:0]  req_ctrl;
    logic [c_NR-1:0]    resp_valid;
    logic [c_NR-1:0]    resp_ready;
    logic [c_W-1:0]     resp_result;
    logic               resp_zero, resp_lt, resp_ltu, resp_err;
    logic [c_W-1:0]     alu_op1, alu_op2;
    logic [3:0]         alu_ctrl;
    logic [c_W-1:0]     alu_result;
    logic               zero, lessSigend, lessUnsigend;

    int n_checks = 0;
    int n_err    = 0;
    int m_ptr    = 0;

    logic [c_W-1:0] t_op1  [c_NR];
    logic [c_W-1:0] t_op2  [c_NR];
    logic [3:0]     t_ctrl [c_NR];

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(c_W), .NUM_REQ(c_NR)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_lt(resp_lt), .resp_ltu(resp_ltu), .resp_err(resp_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .zero(zero),
        .lessSigend(lessSigend), .lessUnsigend(lessUnsigend)
    );

    typedef struct packed {
        logic [c_W-1:0] res;
        logic           z;
        logic           lt;
        logic           ltu;
    } alu_out_t;

    function automatic logic is_legal(input logic [3:0] c);
        return c inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                         4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    endfunction

    function automatic alu_out_t alu_fn(input logic [3:0] c, input logic [c_W-1:0] a,
                                        input logic [c_W-1:0] b);
        alu_out_t o;
        case (c)
            4'b0000: o.res = a + b;
            4'b1000: o.res = a - b;
            4'b0001: o.res = a << b[4:0];
            4'b0010: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: o.res = (a < b) ? 32'd1 : 32'd0;
            4'b0100: o.res = a ^ b;
            4'b0101: o.res = a >> b[4:0];
            4'b1101: o.res = $unsigned($signed(a) >>> b[4:0]);
            4'b0110: o.res = a | b;
            4'b0111: o.res = a & b;
            default: o.res = 32'hDEAD_BEEF;
        endcase
        o.z   = (o.res == 32'd0);
        o.lt  = $signed(a) < $signed(b);
        o.ltu = a < b;
        return o;
    endfunction

    // External ALU: garbage on illegal codes so the DUT must ignore it.
    always_comb begin
        alu_out_t o;
        o = alu_fn(alu_ctrl, alu_op1, alu_op2);
        if (is_legal(alu_ctrl)) begin
            alu_result = o.res; zero = o.z; lessSigend = o.lt; lessUnsigend = o.ltu;
        end else begin
            alu_result = 32'hDEAD_BEEF; zero = 1'b1; lessSigend = 1'b1; lessUnsigend = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_checks++;
            if ($countones(req_ready) > 1) begin
                n_err++;
                $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
            end
        end
    end

    task automatic drive(input logic [c_NR-1:0] mask);
        for (int i = 0; i < c_NR; i++) begin
            req_op1[i*c_W +: c_W] = t_op1[i];
            req_op2[i*c_W +: c_W] = t_op2[i];
            req_ctrl[i*4 +: 4]    = t_ctrl[i];
        end
        req_valid = mask;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ptr   = 0;
    endtask

    // One arbitration round starting in IDLE; eg < 0 means no grant expected.
    task automatic run_txn(input logic [c_NR-1:0] mask, input int stall, input int eg,
                           input logic [c_W-1:0] er, input logic ez, input logic elt,
                           input logic eltu, input logic ee, input string tag);
        logic [c_NR-1:0] oh;
        logic [c_NR-1:0] rr;
        drive(mask);
        #1;
        if (eg < 0) begin
            chk({tag, "_nogrant"}, 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            req_valid = '0;
            return;
        end
        oh = c_NR'(1) << eg;
        chk({tag, "_grant"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = mask & ~oh;
        chk({tag, "_exec_rv"}, 64'(resp_valid), 64'(0));
        chk({tag, "_exec_rdy"}, 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            chk({tag, "_rv"}, 64'(resp_valid), 64'(oh));
            chk({tag, "_res"}, 64'(resp_result), 64'(er));
            chk({tag, "_flags"}, 64'({resp_zero, resp_lt, resp_ltu, resp_err}),
                64'({ez, elt, eltu, ee}));
            chk({tag, "_rdy"}, 64'(req_ready), 64'(0));
            if (s < stall) begin
                rr = c_NR'($urandom);
                rr[eg] = 1'b0;
            end else begin
                rr = oh;
            end
            resp_ready = rr;
            @(posedge clk); #1;
        end
        resp_ready = '0;
        req_valid  = '0;
        chk({tag, "_done_rv"}, 64'(resp_valid), 64'(0));
        m_ptr = (eg + 1) % c_NR;
    endtask

    typedef struct {
        logic [1:0]     mask;
        logic [3:0]     c0, c1;
        logic [c_W-1:0] a0, b0, a1, b1;
        int             stall;
        int             g;
        logic [c_W-1:0] res;
        logic           z, lt, ltu, err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [c_NR-1:0] mask;
        int              eg;
        alu_out_t        o;

        tbl[0]  = '{2'b11, 4'b1000, 4'b0100, 32'hA, 32'hA, 32'hFFFF0000, 32'h0000FFFF, 0, 0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 4'b1000, 4'b0100, 32'hA, 32'hA, 32'hFFFF0000, 32'h0000FFFF, 0, 1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 4'b0000, 4'b0000, 32'hA, 32'h5, 32'h0, 32'h0, 0, 0, 32'hF,                      1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'b10, 4'b0000, 4'b0110, 32'h0, 32'h0, 32'hF0, 32'h0F, 0, 1, 32'hFF,                   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2'b11, 4'b0111, 4'b1101, 32'hFF00FF00, 32'h0FF00FF0, 32'h80000000, 32'h8, 5, 0, 32'h0F000F00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 4'b0111, 4'b1101, 32'hFF00FF00, 32'h0FF00FF0, 32'h80000000, 32'h8, 0, 1, 32'hFF800000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 4'b0000, 4'b1001, 32'h0, 32'h0, 32'h12345678, 32'h1, 1, 1, 32'h0,              1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{2'b01, 4'b0011, 4'b0000, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 32'h1,              1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b10, 4'b0000, 4'b0001, 32'h0, 32'h0, 32'h1, 32'd31, 0, 1, 32'h80000000,             1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{2'b01, 4'b0101, 4'b0000, 32'h80000000, 32'h4, 32'h0, 32'h0, 2, 0, 32'h08000000,       1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0, -1, 32'h0,                    1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'b11, 4'b0000, 4'b0010, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 0, 1, 32'h1,       1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 4'b0000, 4'b1000, 32'hFFFFFFFF, 32'h1, 32'h5, 32'h7, 0, 0, 32'h0,              1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{2'b11, 4'b0000, 4'b1000, 32'hFFFFFFFF, 32'h1, 32'h5, 32'h7, 0, 1, 32'hFFFFFFFE,       1'b0, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < c_NR; i++) begin
            t_op1[i] = '0; t_op2[i] = '0; t_ctrl[i] = '0;
        end
        req_op1 = '0; req_op2 = '0; req_ctrl = '0;
        do_reset();

        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_result", 64'(resp_result), 64'(0));
        chk("rst_flags", 64'({resp_zero, resp_lt, resp_ltu, resp_err}), 64'(0));
        chk("rst_alu_ops", 64'({alu_op1 | alu_op2, alu_ctrl}), 64'(0));

        for (int v = 0; v < 14; v++) begin
            t_ctrl[0] = tbl[v].c0; t_op1[0] = tbl[v].a0; t_op2[0] = tbl[v].b0;
            t_ctrl[1] = tbl[v].c1; t_op1[1] = tbl[v].a1; t_op2[1] = tbl[v].b1;
            run_txn(tbl[v].mask, tbl[v].stall, tbl[v].g, tbl[v].res,
                    tbl[v].z, tbl[v].lt, tbl[v].ltu, tbl[v].err, $sformatf("vec%0d", v));
        end

        // Reset while an SLT is in EXEC: nothing may come out and ptr returns to 0.
        t_ctrl[0] = 4'b0000; t_op1[0] = 32'h1; t_op2[0] = 32'h2;
        run_txn(2'b01, 0, 0, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0, "pre_rst");
        t_ctrl[1] = 4'b0010; t_op1[1] = 32'hFFFFFFFF; t_op2[1] = 32'h0;
        drive(2'b10);
        #1;
        chk("midrst_grant", 64'(req_ready), 64'(2'b10));
        @(posedge clk); #1;
        req_valid = '0;
        reset_n   = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rv", 64'(resp_valid), 64'(0));
        chk("midrst_res", 64'(resp_result), 64'(0));
        chk("midrst_flags", 64'({resp_zero, resp_lt, resp_ltu, resp_err}), 64'(0));
        chk("midrst_alu", 64'({alu_op1 | alu_op2, alu_ctrl}), 64'(0));
        reset_n = 1'b1;
        m_ptr   = 0;
        @(posedge clk); #1;
        chk("midrst_no_resp", 64'(resp_valid), 64'(0));
        t_ctrl[0] = 4'b0010; t_op1[0] = 32'hFFFFFFFF; t_op2[0] = 32'h0;
        run_txn(2'b11, 0, 0, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, "slt_after_rst");

        // Randomized rounds scored against the round-robin and ALU rules.
        for (int n = 0; n < 60; n++) begin
            mask = c_NR'($urandom_range(0, 3));
            for (int i = 0; i < c_NR; i++) begin
                t_ctrl[i] = 4'($urandom_range(0, 15));
                t_op1[i]  = $urandom;
                t_op2[i]  = ($urandom_range(0, 3) == 0) ? t_op1[i] : $urandom;
            end
            eg = -1;
            for (int k = 0; k < c_NR; k++) begin
                if (mask[(m_ptr + k) % c_NR] && eg < 0) eg = (m_ptr + k) % c_NR;
            end
            if (eg >= 0 && is_legal(t_ctrl[eg])) begin
                o = alu_fn(t_ctrl[eg], t_op1[eg], t_op2[eg]);
                run_txn(mask, $urandom_range(0, 3), eg, o.res, o.z, o.lt, o.ltu, 1'b0,
                        $sformatf("rnd%0d", n));
            end else begin
                run_txn(mask, $urandom_range(0, 3), eg, 32'h0, 1'b0, 1'b0, 1'b0, eg >= 0,
                        $sformatf("rnd%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
